// File: rtl/udp_filter_pkg.sv
// Shared constants and types for the UDP rule filter.
// Header byte offsets, register map and rule/control records.
package udp_filter_pkg;

  localparam int OFF_MAC   = 0;
  localparam int OFF_ETYPE = 12;
  localparam int OFF_VIHL  = 14;
  localparam int OFF_PROTO = 23;
  localparam int OFF_DIP   = 30;
  localparam int OFF_DPORT = 36;

  localparam logic [7:0] A_MAC_LO = 8'h00;
  localparam logic [7:0] A_MAC_HI = 8'h01;
  localparam logic [7:0] A_ETYPE  = 8'h02;
  localparam logic [7:0] A_PROTO  = 8'h03;
  localparam logic [7:0] A_CTRL   = 8'h04;
  localparam logic [7:0] A_DROP   = 8'h05;
  localparam logic [7:0] A_RULE0  = 8'h10;

  typedef struct packed {
    logic        en;
    logic [15:0] port;
    logic [31:0] base;
    logic [31:0] mask;
  } rule_t;

  typedef struct packed {
    logic dflt_pass;
    logic enable;
  } ctrl_t;

  function automatic logic [7:0] rule_addr(
    input int r,
    input int k
  );
    return 8'(int'(A_RULE0) + 4 * r + k);
  endfunction

endpackage

// File: rtl/udp_rule_filter_if.sv
// Header/decision handshakes and config bus of the UDP rule filter.
// master drives headers and config, slave is the filter.
interface udp_rule_filter_if #(
  parameter int N_RULES = 4
);
  localparam int RULE_W = (N_RULES > 1) ? $clog2(N_RULES) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [511:0]      in_hdr;
  logic              out_valid;
  logic              out_ready;
  logic              out_pass;
  logic [RULE_W-1:0] out_rule;
  logic              cfg_we;
  logic [7:0]        cfg_waddr;
  logic [31:0]       cfg_wdata;
  logic [7:0]        cfg_raddr;
  logic [31:0]       cfg_rdata;

  modport master (
    output in_valid, in_hdr, out_ready,
    output cfg_we, cfg_waddr, cfg_wdata, cfg_raddr,
    input  in_ready, out_valid, out_pass, out_rule,
    input  cfg_rdata
  );

  modport slave (
    input  in_valid, in_hdr, out_ready,
    input  cfg_we, cfg_waddr, cfg_wdata, cfg_raddr,
    output in_ready, out_valid, out_pass, out_rule,
    output cfg_rdata
  );

endinterface

// File: rtl/udp_filter_regs.sv
// Config register file, rule table and hit/drop counters.
// Counters exist only when UDP_FILTER_STATS_EN is defined.
module udp_filter_regs
  import udp_filter_pkg::*;
#(
  parameter int N_RULES = 4,
  parameter int CNT_W   = 32,
  parameter int RULE_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [7:0]        cfg_waddr,
  input  logic [31:0]       cfg_wdata,
  input  logic [7:0]        cfg_raddr,
  output logic [31:0]       cfg_rdata,
  output logic [47:0]       mac,
  output logic [15:0]       etype,
  output logic [7:0]        proto,
  output ctrl_t             ctrl,
  output rule_t             rules [N_RULES],
  input  logic              cnt_hit,
  input  logic              cnt_drop,
  input  logic [RULE_W-1:0] cnt_idx
);

  logic [31:0] drop_rd;
  logic [31:0] hit_rd [N_RULES];

  // global and per-rule config writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac   <= '0;
      etype <= '0;
      proto <= '0;
      ctrl  <= '0;
      for (int r = 0; r < N_RULES; r++) rules[r] <= '0;
    end else if (cfg_we) begin
      case (cfg_waddr)
        A_MAC_LO: mac[31:0]  <= cfg_wdata;
        A_MAC_HI: mac[47:32] <= cfg_wdata[15:0];
        A_ETYPE:  etype      <= cfg_wdata[15:0];
        A_PROTO:  proto      <= cfg_wdata[7:0];
        A_CTRL:   ctrl       <= ctrl_t'(cfg_wdata[1:0]);
        default: ;
      endcase
      for (int r = 0; r < N_RULES; r++) begin
        if (cfg_waddr == rule_addr(r, 0))
          rules[r].base <= cfg_wdata;
        if (cfg_waddr == rule_addr(r, 1))
          rules[r].mask <= cfg_wdata;
        if (cfg_waddr == rule_addr(r, 2)) begin
          rules[r].en   <= cfg_wdata[16];
          rules[r].port <= cfg_wdata[15:0];
        end
      end
    end
  end

`ifdef UDP_FILTER_STATS_EN
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] hit_cnt [N_RULES];

  // saturating counters; a clear write beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      for (int r = 0; r < N_RULES; r++) hit_cnt[r] <= '0;
    end else begin
      if (cfg_we && cfg_waddr == A_DROP)
        drop_cnt <= '0;
      else if (cnt_drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_W'(1);
      for (int r = 0; r < N_RULES; r++) begin
        if (cfg_we && cfg_waddr == rule_addr(r, 3))
          hit_cnt[r] <= '0;
        else if (cnt_hit && cnt_idx == RULE_W'(r)
                 && hit_cnt[r] != '1)
          hit_cnt[r] <= hit_cnt[r] + CNT_W'(1);
      end
    end
  end

  // widen counters for readback
  always_comb begin
    drop_rd = 32'(drop_cnt);
    for (int r = 0; r < N_RULES; r++) hit_rd[r] = 32'(hit_cnt[r]);
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_hit, cnt_drop, cnt_idx};

  // counters absent: their addresses read as zero
  always_comb begin
    drop_rd = '0;
    for (int r = 0; r < N_RULES; r++) hit_rd[r] = '0;
  end
`endif

  // combinational readback; unmapped addresses return zero
  always_comb begin
    cfg_rdata = '0;
    case (cfg_raddr)
      A_MAC_LO: cfg_rdata = mac[31:0];
      A_MAC_HI: cfg_rdata = {16'd0, mac[47:32]};
      A_ETYPE:  cfg_rdata = {16'd0, etype};
      A_PROTO:  cfg_rdata = {24'd0, proto};
      A_CTRL:   cfg_rdata = {30'd0, ctrl};
      A_DROP:   cfg_rdata = drop_rd;
      default: ;
    endcase
    for (int r = 0; r < N_RULES; r++) begin
      if (cfg_raddr == rule_addr(r, 0))
        cfg_rdata = rules[r].base;
      if (cfg_raddr == rule_addr(r, 1))
        cfg_rdata = rules[r].mask;
      if (cfg_raddr == rule_addr(r, 2))
        cfg_rdata = {15'd0, rules[r].en, rules[r].port};
      if (cfg_raddr == rule_addr(r, 3))
        cfg_rdata = hit_rd[r];
    end
  end

endmodule

// File: rtl/udp_rule_filter.sv
// Two-stage Ethernet/IPv4/UDP header filter with N_RULES rules.
// Build with UDP_FILTER_STATS_EN for hit/drop counters.
module udp_rule_filter
  import udp_filter_pkg::*;
#(
  parameter int N_RULES = 4,
  parameter int CNT_W   = 32
) (
  input logic               clk,
  input logic               rst_n,
  udp_rule_filter_if.slave  bus
);

  localparam int RULE_W = (N_RULES > 1) ? $clog2(N_RULES) : 1;

  logic [47:0]       mac;
  logic [15:0]       etype;
  logic [7:0]        proto;
  ctrl_t             ctrl;
  rule_t             rules [N_RULES];

  logic [31:0]       dip;
  logic [15:0]       dport;
  logic              g_ok;
  logic [N_RULES-1:0] hit;

  logic              s1_valid;
  logic              s1_g;
  logic              s1_en;
  logic              s1_dp;
  logic [N_RULES-1:0] s1_hit;

  logic              adv2;
  logic              any_hit;
  logic [RULE_W-1:0] idx;
  logic              out_hit;
  logic              hs_out;

  assign adv2         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || adv2;
  assign hs_out       = bus.out_valid && bus.out_ready;

  assign dip   = bus.in_hdr[511-8*OFF_DIP -: 32];
  assign dport = bus.in_hdr[511-8*OFF_DPORT -: 16];

  // global L2/L3 check and per-rule match on the incoming header
  always_comb begin
    g_ok = (bus.in_hdr[511-8*OFF_MAC -: 48] == mac)
        && (bus.in_hdr[511-8*OFF_ETYPE -: 16] == etype)
        && (bus.in_hdr[511-8*OFF_VIHL -: 8] == 8'h45)
        && (bus.in_hdr[511-8*OFF_PROTO -: 8] == proto);
    for (int r = 0; r < N_RULES; r++)
      hit[r] = rules[r].en
            && ((dip & rules[r].mask) == rules[r].base)
            && (dport == rules[r].port);
  end

  // stage 1: capture match results with the config of this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_g     <= 1'b0;
      s1_en    <= 1'b0;
      s1_dp    <= 1'b0;
      s1_hit   <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_g   <= g_ok;
        s1_en  <= ctrl.enable;
        s1_dp  <= ctrl.dflt_pass;
        s1_hit <= hit;
      end
    end
  end

  // lowest-index hit wins
  always_comb begin
    idx = '0;
    for (int r = N_RULES - 1; r >= 0; r--)
      if (s1_hit[r]) idx = RULE_W'(r);
  end

  assign any_hit = |s1_hit;

  // stage 2: decision register, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_pass  <= 1'b0;
      bus.out_rule  <= '0;
      out_hit       <= 1'b0;
    end else if (adv2) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_pass <= s1_en && s1_g && (any_hit || s1_dp);
        bus.out_rule <= idx;
        out_hit      <= any_hit;
      end
    end
  end

  udp_filter_regs #(
    .N_RULES (N_RULES),
    .CNT_W   (CNT_W),
    .RULE_W  (RULE_W)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (bus.cfg_we),
    .cfg_waddr (bus.cfg_waddr),
    .cfg_wdata (bus.cfg_wdata),
    .cfg_raddr (bus.cfg_raddr),
    .cfg_rdata (bus.cfg_rdata),
    .mac       (mac),
    .etype     (etype),
    .proto     (proto),
    .ctrl      (ctrl),
    .rules     (rules),
    .cnt_hit   (hs_out && bus.out_pass && out_hit),
    .cnt_drop  (hs_out && !bus.out_pass),
    .cnt_idx   (bus.out_rule)
  );

endmodule

// File: tb/tb_udp_rule_filter.sv
// Directed plus randomized bench for udp_rule_filter.
// Counter expectations follow UDP_FILTER_STATS_EN.
module tb_udp_rule_filter;

  localparam int NR   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
`ifdef UDP_FILTER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  udp_rule_filter_if #(.N_RULES(NR)) bus ();

  udp_rule_filter #(
    .N_RULES (NR),
    .CNT_W   (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [47:0] m_mac;
  logic [15:0] m_et;
  logic [7:0]  m_pr;
  bit          m_en;
  bit          m_dp;
  logic [31:0] m_base [NR];
  logic [31:0] m_mask [NR];
  logic [15:0] m_port [NR];
  bit          m_ren  [NR];
  int          m_hit  [NR];
  int          m_drop;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mac = '0; m_et = '0; m_pr = '0; m_en = 0; m_dp = 0; m_drop = 0;
    for (int r = 0; r < NR; r++) begin
      m_base[r] = '0; m_mask[r] = '0; m_port[r] = '0;
      m_ren[r] = 0; m_hit[r] = 0;
    end
  endfunction

  function automatic void model_write(input int a, input logic [31:0] d);
    int r;
    if (a == 0) m_mac[31:0] = d;
    else if (a == 1) m_mac[47:32] = d[15:0];
    else if (a == 2) m_et = d[15:0];
    else if (a == 3) m_pr = d[7:0];
    else if (a == 4) begin m_en = d[0]; m_dp = d[1]; end
    else if (a == 5) m_drop = 0;
    else if (a >= 16 && a < 16 + 4 * NR) begin
      r = (a - 16) / 4;
      case ((a - 16) % 4)
        0: m_base[r] = d;
        1: m_mask[r] = d;
        2: begin m_port[r] = d[15:0]; m_ren[r] = d[16]; end
        default: m_hit[r] = 0;
      endcase
    end
  endfunction

  function automatic void model_decide(input logic [511:0] h,
      output bit pass, output int rule, output bit hit);
    logic [7:0]  b [64];
    logic [31:0] ip;
    logic [15:0] pt;
    bit g;
    for (int k = 0; k < 64; k++) b[k] = h[511-8*k -: 8];
    g = 1;
    for (int k = 0; k < 6; k++)
      if (b[k] != m_mac[8*(5-k) +: 8]) g = 0;
    if ({b[12], b[13]} != m_et) g = 0;
    if (b[14] != 8'h45) g = 0;
    if (b[23] != m_pr) g = 0;
    ip = {b[30], b[31], b[32], b[33]};
    pt = {b[36], b[37]};
    hit = 0;
    rule = 0;
    for (int r = 0; r < NR; r++)
      if (!hit && m_ren[r] && (ip & m_mask[r]) == m_base[r]
          && pt == m_port[r]) begin
        hit = 1;
        rule = r;
      end
    pass = m_en && g && (hit || m_dp);
  endfunction

  function automatic void model_count(input bit pass, input int rule,
                                      input bit hit);
    if (pass && hit) begin
      if (m_hit[rule] < CMAX) m_hit[rule]++;
    end else if (!pass) begin
      if (m_drop < CMAX) m_drop++;
    end
  endfunction

  function automatic logic [511:0] make_hdr(input logic [47:0] mc,
      input logic [15:0] et, input logic [7:0] vi, input logic [7:0] pr,
      input logic [31:0] ip, input logic [15:0] pt);
    logic [511:0] h;
    for (int i = 0; i < 16; i++) h[32*i +: 32] = $urandom;
    h[511 -: 48]     = mc;
    h[511-96 -: 16]  = et;
    h[511-112 -: 8]  = vi;
    h[511-184 -: 8]  = pr;
    h[511-240 -: 32] = ip;
    h[511-288 -: 16] = pt;
    return h;
  endfunction

  function automatic logic [511:0] good_hdr(input logic [31:0] ip,
                                            input logic [15:0] pt);
    return make_hdr(m_mac, m_et, 8'h45, m_pr, ip, pt);
  endfunction

  function automatic logic [511:0] rand_hdr();
    logic [47:0] mc;
    logic [15:0] et;
    logic [7:0]  vi;
    logic [7:0]  pr;
    logic [31:0] ip;
    logic [15:0] pt;
    mc = ($urandom_range(0, 9) == 0) ? (m_mac ^ 48'h010000) : m_mac;
    et = ($urandom_range(0, 9) == 0) ? 16'h86dd : m_et;
    vi = ($urandom_range(0, 9) == 0) ? 8'h46 : 8'h45;
    pr = ($urandom_range(0, 9) == 0) ? 8'h06 : m_pr;
    case ($urandom_range(0, 3))
      0: ip = 32'h0A010203;
      1: ip = 32'h0A020909;
      2: ip = 32'h0B000001;
      default: ip = $urandom;
    endcase
    case ($urandom_range(0, 2))
      0: pt = 16'd5000;
      1: pt = 16'd6000;
      default: pt = 16'($urandom_range(0, 65535));
    endcase
    return make_hdr(mc, et, vi, pr, ip, pt);
  endfunction

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    bus.cfg_we = 1'b1;
    bus.cfg_waddr = a;
    bus.cfg_wdata = d;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    model_write(int'(a), d);
  endtask

  task automatic check_reg(input string tag, input logic [7:0] a,
                           input logic [31:0] exp);
    bus.cfg_raddr = a;
    #1;
    check(tag, bus.cfg_rdata, exp);
  endtask

  task automatic check_cnts(input string tag);
    check_reg({tag, ".drop"}, 8'h05, STATS ? 32'(m_drop) : 32'd0);
    for (int r = 0; r < NR; r++)
      check_reg($sformatf("%s.hit%0d", tag, r), 8'(16 + 4 * r + 3),
                STATS ? 32'(m_hit[r]) : 32'd0);
  endtask

  task automatic send_check(input string tag, input logic [511:0] h);
    bit p;
    bit hh;
    int r;
    model_decide(h, p, r, hh);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_hdr = h;
    #1;
    check({tag, ".rdy"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({tag, ".lat1"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, ".lat2"}, 32'(bus.out_valid), 32'd1);
    check({tag, ".pass"}, 32'(bus.out_pass), 32'(p));
    check({tag, ".rule"}, 32'(bus.out_rule), 32'(r));
    @(posedge clk); #1;
    model_count(p, r, hh);
    check({tag, ".done"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [511:0] sh [6];
    bit  ep [6];
    int  er [6];
    bit  eh [6];
    int  sent;
    int  rcv;
    bit  saw_low;
    bit  stall;
    bit  hi;
    bit  sv_p;
    int  sv_r;
    bit  p;
    bit  hh;
    int  r;
    logic [511:0] h;

    bus.in_valid = 1'b0;
    bus.in_hdr = '0;
    bus.out_ready = 1'b1;
    bus.cfg_we = 1'b0;
    bus.cfg_waddr = '0;
    bus.cfg_wdata = '0;
    bus.cfg_raddr = '0;
    model_reset();

    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    check_reg("reset.ctrl", 8'h04, 32'd0);
    check_reg("reset.base0", 8'h10, 32'd0);
    check_cnts("reset");

    cfg_write(8'h00, 32'h22334455);
    cfg_write(8'h01, 32'h00000011);
    cfg_write(8'h02, 32'h00000800);
    cfg_write(8'h03, 32'h00000011);
    cfg_write(8'h04, 32'h00000001);
    cfg_write(8'h10, 32'h0A000000);
    cfg_write(8'h11, 32'hFF000000);
    cfg_write(8'h12, 32'h00011388);
    check_reg("rd.mac_hi", 8'h01, 32'h00000011);
    check_reg("rd.rule0", 8'h12, 32'h00011388);
    check_reg("rd.unmapped", 8'h0F, 32'd0);
    check_reg("rd.past_rules", 8'h20, 32'd0);

    send_check("rule0", good_hdr(32'h0A010203, 16'd5000));
    check_cnts("rule0");

    cfg_write(8'h12, 32'h00001388);
    cfg_write(8'h14, 32'h0A010000);
    cfg_write(8'h15, 32'hFFFF0000);
    cfg_write(8'h16, 32'h00011388);
    cfg_write(8'h1C, 32'h00000000);
    cfg_write(8'h1D, 32'h00000000);
    cfg_write(8'h1E, 32'h00011388);
    send_check("r1r3", good_hdr(32'h0A010203, 16'd5000));
    check_cnts("r1r3");

    send_check("portmiss", good_hdr(32'h0A010203, 16'd6000));
    check_cnts("portmiss");
    cfg_write(8'h04, 32'h00000003);
    send_check("dflt", good_hdr(32'h0A010203, 16'd6000));
    check_cnts("dflt");

    send_check("g.mac", make_hdr(m_mac ^ 48'h1, m_et, 8'h45, m_pr,
                                 32'h0A010203, 16'd5000));
    send_check("g.etype", make_hdr(m_mac, 16'h0806, 8'h45, m_pr,
                                   32'h0A010203, 16'd5000));
    send_check("g.vihl", make_hdr(m_mac, m_et, 8'h46, m_pr,
                                  32'h0A010203, 16'd5000));
    send_check("g.proto", make_hdr(m_mac, m_et, 8'h45, 8'h06,
                                   32'h0A010203, 16'd5000));
    cfg_write(8'h04, 32'h00000002);
    send_check("disabled", good_hdr(32'h0A010203, 16'd5000));
    cfg_write(8'h04, 32'h00000001);

    cfg_write(8'h14, 32'h0A010001);
    send_check("base_out", good_hdr(32'h0A010001, 16'd5000));
    cfg_write(8'h14, 32'h0A010000);
    check_cnts("global");

    cfg_write(8'h12, 32'h00011388);
    for (int i = 0; i < 5; i++)
      send_check("sat", good_hdr(32'h0A000005, 16'd5000));
    check_reg("sat.hit0", 8'h13, STATS ? 32'd3 : 32'd0);
    check_cnts("sat");

    h = good_hdr(32'h0A000005, 16'd5000);
    model_decide(h, p, r, hh);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_hdr = h;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("clr.valid", 32'(bus.out_valid), 32'd1);
    bus.cfg_we = 1'b1;
    bus.cfg_waddr = 8'h13;
    bus.cfg_wdata = 32'd0;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
    model_count(p, r, hh);
    model_write(8'h13, 32'd0);
    check_reg("clr.hit0", 8'h13, 32'd0);
    check_cnts("clr");

    cfg_write(8'h04, 32'h00000001);
    cfg_write(8'h18, 32'h0B000000);
    cfg_write(8'h19, 32'hFF000000);
    cfg_write(8'h1A, 32'h00011770);
    cfg_write(8'h1E, 32'h00011770);

    for (int i = 0; i < 6; i++) begin
      sh[i] = rand_hdr();
      model_decide(sh[i], ep[i], er[i], eh[i]);
    end
    sent = 0;
    rcv = 0;
    saw_low = 0;
    for (int c = 0; c < 60 && rcv < 6; c++) begin
      bus.out_ready = !(c >= 3 && c <= 5);
      bus.in_valid = (sent < 6);
      bus.in_hdr = sh[(sent < 6) ? sent : 0];
      #1;
      hi = bus.in_valid && bus.in_ready;
      if (!bus.in_ready) saw_low = 1;
      if (bus.out_valid && bus.out_ready) begin
        if (rcv < 6) begin
          check($sformatf("strm%0d.pass", rcv), 32'(bus.out_pass),
                32'(ep[rcv]));
          check($sformatf("strm%0d.rule", rcv), 32'(bus.out_rule),
                32'(er[rcv]));
          model_count(ep[rcv], er[rcv], eh[rcv]);
        end else begin
          check("strm.extra", 32'(rcv), 32'd6);
        end
        rcv++;
      end
      stall = bus.out_valid && !bus.out_ready;
      sv_p = bus.out_pass;
      sv_r = int'(bus.out_rule);
      @(posedge clk); #1;
      if (stall) begin
        check("stall.valid", 32'(bus.out_valid), 32'd1);
        check("stall.pass", 32'(bus.out_pass), 32'(sv_p));
        check("stall.rule", 32'(bus.out_rule), 32'(sv_r));
      end
      if (hi) sent++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("strm.sent", 32'(sent), 32'd6);
    check("strm.rcv", 32'(rcv), 32'd6);
    check("strm.backpressure", 32'(saw_low), 32'd1);
    @(posedge clk); #1;
    check("strm.drained", 32'(bus.out_valid), 32'd0);
    check_cnts("strm");

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0)
        cfg_write(8'h04, 32'($urandom_range(1, 3)));
      send_check($sformatf("rnd%0d", i), rand_hdr());
    end
    check_cnts("rnd");

    cfg_write(8'h04, 32'h00000001);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_hdr = good_hdr(32'h0B000001, 16'd6000);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst.pre_valid", 32'(bus.out_valid), 32'd1);
    check("rst.pre_rule", 32'(bus.out_rule), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.out_pass", 32'(bus.out_pass), 32'd0);
    check("rst.out_rule", 32'(bus.out_rule), 32'd0);
    check_reg("rst.ctrl", 8'h04, 32'd0);
    check_cnts("rst");
    bus.out_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.no_stale", 32'(bus.out_valid), 32'd0);
    send_check("post_rst", rand_hdr());
    check_cnts("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
